// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the external 16-bit SRAM bridge.
package sram_controller_pkg;

    // Access sequencer states: request accepted, low half, high half, completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    // CPU byte address that lands on SRAM word 0.
    localparam logic [31:0] DEFAULT_BASE_ADDR     = 32'd1024;
    localparam int          DEFAULT_ACCESS_CYCLES = 2;

endpackage

// File: rtl/sram_controller_if.sv
// CPU-side MEM-stage bus of the SRAM bridge: one 32-bit load or store per request.
interface sram_controller_if;

    logic        wrEnIn;
    logic        rdEnIn;
    logic [31:0] addressIn;
    logic [31:0] writeDataIn;
    logic [31:0] readDataOut;
    logic        readyOut;

    // Pipeline side issues requests and freezes while readyOut is low.
    modport master (
        output wrEnIn, rdEnIn, addressIn, writeDataIn,
        input  readDataOut, readyOut
    );

    // Controller side.
    modport slave (
        input  wrEnIn, rdEnIn, addressIn, writeDataIn,
        output readDataOut, readyOut
    );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit CPU load/store into two timed 16-bit accesses to an
// external asynchronous SRAM, low half first. The pad tristate is built by
// the enclosing top level from SRAM_DQ_Out / SRAM_DQ_OE / SRAM_DQ_In.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    // Clocks per 16-bit half-access; must be at least 2 so the write strobe
    // can rise one cycle before address and data change.
    parameter int          ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       bus,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic [SRAM_DATA_W-1:0] SRAM_DQ_Out,
    output logic                   SRAM_DQ_OE,
    input  logic [SRAM_DATA_W-1:0] SRAM_DQ_In,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam int                CNT_W    = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         wait_cnt;
    logic                     op_write;
    logic [SRAM_DATA_W-1:0]   low_half;
    logic [31:0]              read_data;
    logic                     chip_off;
    logic                     req;
    logic                     phase_last;
    logic [SRAM_ADDR_W-2:0]   word_idx;

    assign req        = bus.wrEnIn | bus.rdEnIn;
    assign phase_last = (wait_cnt == LAST_CNT);
    // Offset from the window base wraps modulo 2^32; the byte lane bits drop out.
    assign word_idx   = (SRAM_ADDR_W - 1)'((bus.addressIn - BASE_ADDR) >> 2);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block evaluation order.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a request leaves IDLE, each phase lasts ACCESS_CYCLES clocks.
    always_comb begin
        // NOTE: the default assignment up front keeps every path assigned, so
        // no latch is inferred for the hold-state case.
        state_nxt = state;
        case (state)
            IDLE: if (req)        state_nxt = LOW;
            LOW:  if (phase_last) state_nxt = HIGH;
            HIGH: if (phase_last) state_nxt = DONE;
            DONE:                 state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Phase timer, operation latch, load result and chip-enable register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt  <= '0;
            op_write  <= 1'b0;
            read_data <= '0;
            chip_off  <= 1'b1;
        end else begin
            chip_off <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_write <= bus.wrEnIn;
                        wait_cnt <= '0;
                    end
                end
                LOW, HIGH: begin
                    wait_cnt <= phase_last ? '0 : wait_cnt + 1'b1;
                    if (!op_write && phase_last && state == HIGH) begin
                        read_data <= {SRAM_DQ_In, low_half};
                    end
                end
                default: ;
            endcase
        end
    end

    // Low-half holding register for loads.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; low_half is always rewritten at the end of LOW
        // before HIGH can use it, so a reset branch would only cost logic.
        if (state == LOW && !op_write && phase_last) begin
            low_half <= SRAM_DQ_In;
        end
    end

    // SRAM pin drive as a function of state, phase timer and latched operation.
    always_comb begin
        SRAM_ADDR   = '0;
        SRAM_DQ_Out = '0;
        SRAM_DQ_OE  = 1'b0;
        SRAM_WE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        if (state == LOW || state == HIGH) begin
            SRAM_ADDR = {word_idx, (state == HIGH)};
            if (op_write) begin
                SRAM_DQ_OE  = 1'b1;
                SRAM_DQ_Out = (state == HIGH) ? bus.writeDataIn[31:16]
                                              : bus.writeDataIn[15:0];
                // Strobe rises on the last cycle so address/data are held past it.
                SRAM_WE_N   = phase_last;
            end else begin
                SRAM_OE_N = 1'b0;
            end
        end
    end

    assign bus.readyOut    = (state == IDLE && !req) || (state == DONE);
    assign bus.readDataOut = read_data;
    assign SRAM_CE_N       = chip_off;
    assign SRAM_UB_N       = chip_off;
    assign SRAM_LB_N       = chip_off;

endmodule
